mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Sequences every load/store leaving the memory stage onto the Dcache request/response interface.
- Checks alignment; generates byte strobes and lane-shifted store data.
- Holds the pipeline while the access is in flight; enforces a response timeout.
- Returns sign/zero-extended load data to the mem/wb path.
- Sits between the memory stage outputs and the Dcache, and drives the pipeline stall line.

Parameters:
- TIMEOUT_CYC, 64, max cycles in WAIT before a bus error is declared (≥2).
- CNT_W, 7, timeout counter width (must hold TIMEOUT_CYC).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid_req_i  in  1  memory instruction present in mem stage.
- mem_rw_i  in  1  1=store, 0=load.
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_rdtype_i  in  1  load extension: 0 signed, 1 unsigned.
- mem_addr_i  in  32  byte address.
- mem_wr_data_i  in  32  store data, right-justified.
- flush_i  in  1  pipeline flush.
- dc_req_valid_o  out  1  request to Dcache.
- dc_req_ready_i  in  1  Dcache accepts request.
- dc_req_rw_o  out  1  copy of latched rw.
- dc_req_addr_o  out  32  latched address with [1:0] forced to 0.
- dc_req_wstrb_o  out  4  byte enables; 0000 for loads.
- dc_req_wdata_o  out  32  store data shifted to byte lane.
- dc_resp_valid_i  in  1  Dcache response.
- dc_resp_rdata_i  in  32  aligned read word.
- stall_o  out  1  hold pipeline.
- done_o  out  1  one-cycle pulse, access complete.
- ld_data_o  out  32  extended load data, valid with done_o, held until next done_o.
- misalign_o  out  1  one-cycle pulse, misaligned/reserved access rejected.
- bus_err_o  out  1  one-cycle pulse with done_o on timeout.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE; all outputs 0; latched registers, ld_data_o and counter cleared.
- Alignment: misaligned when half with addr[0]=1, word with addr[1:0]≠00, or width=11.
- IDLE, mem_valid_req_i & misaligned & !flush_i:
  - misalign_o=1 for that cycle (combinational); stall_o=0; no request issued.
- IDLE, mem_valid_req_i & aligned & !flush_i:
  - stall_o=1 combinationally in the same cycle.
  - Latch rw, width, rdtype, addr and wdata; → REQ.
- REQ:
  - dc_req_valid_o=1 and stall_o=1.
  - Request fields stay stable until accepted.
  - valid/ready both high → WAIT, counter cleared.
- WAIT:
  - stall_o=1; counter increments each cycle.
  - dc_resp_valid_i is sampled only here; the Dcache never responds in the accept cycle.
  - Response → DONE; ld_data_o is registered from the formatted rdata.
  - Counter = TIMEOUT_CYC-1 with no response → DONE; bus_err_o armed; ld_data_o=0.
- DONE:
  - stall_o=0; done_o=1; bus_err_o=1 if armed.
  - mem inputs are ignored; → IDLE.
  - The pipeline advances at the end of this cycle.
- Store formatting, with off = addr[1:0]:
  - byte: wstrb = 0001<<off; wdata = {4{wr_data[7:0]}}.
  - half: wstrb = 0011<<off; wdata = {2{wr_data[15:0]}}.
  - word: wstrb = 1111; wdata = wr_data.
- Load formatting: select byte/half at off from rdata; sign- or zero-extend per rdtype; word passes through.
- Flush:
  - IDLE: the request is suppressed (no misalign_o).
  - REQ: abort to IDLE provided ready is low in that cycle. If ready is high in the same cycle, acceptance wins and the flush is recorded.
  - WAIT: cannot abort. The response (or timeout) is drained with done_o, ld_data_o and bus_err_o suppressed, then → IDLE directly.
  - Flush recorded at acceptance: handled exactly like a flush in WAIT.
- Rest of behaviour:
  - Reset mid-access returns to IDLE immediately. A later Dcache response is ignored because IDLE does not sample it.
  - A store completes only on its response, the same as a load.
- Latency: with ready=1 in REQ and the response one cycle after accept, the access is IDLE→REQ→WAIT→DONE. That is 3 stall cycles, and done_o is asserted in cycle 4.

Test Plan:
- Load byte signed, addr 0x1003, rdata 0x80AABBCC, ready immediate, resp 1 cycle later → ld_data_o=0xFFFFFF80, done_o in cycle 4, stall_o high cycles 1–3.
- Store half, addr 0x2002, wr_data 0x0000BEEF → dc_req_addr_o=0x2000, wstrb=1100, wdata=0xBEEFBEEF; done_o after response.
- Load word, addr 0x3001 → misalign_o=1 for one cycle, dc_req_valid_o never asserted, stall_o=0.
- Ready held low 5 cycles in REQ → dc_req_valid_o and request fields stable throughout; flush_i on 3rd cycle → IDLE, no done_o.
- No response, TIMEOUT_CYC=8 → after 8 WAIT cycles, done_o=1 and bus_err_o=1 together, ld_data_o=0.
- Load half unsigned, addr 0x4002, rdata 0x9ABC1234 → ld_data_o=0x00009ABC; rst asserted in WAIT on a second access → IDLE, later resp ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: checks alignment, formats store lanes and load data,
// and runs one Dcache request/response transaction per access while stalling the pipeline.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_req_i,
  input  logic        mem_rw_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_rdtype_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic        flush_i,
  output logic        dc_req_valid_o,
  input  logic        dc_req_ready_i,
  output logic        dc_req_rw_o,
  output logic [31:0] dc_req_addr_o,
  output logic [3:0]  dc_req_wstrb_o,
  output logic [31:0] dc_req_wdata_o,
  input  logic        dc_resp_valid_i,
  input  logic [31:0] dc_resp_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             rw, rdtype, err_armed, drain, misaligned, timeout, drain_now;
  logic [1:0]       width;
  logic [31:0]      addr, wdata, ld_data;
  logic [CNT_W-1:0] cnt;

  // Select the byte/half at the access offset from the aligned word and extend it.
  function automatic logic [31:0] load_format(input logic [31:0] rdata, input logic [1:0] w,
                                              input logic unsigned_ld, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (w)
      2'b00:   return {{24{~unsigned_ld & b[7]}}, b};
      2'b01:   return {{16{~unsigned_ld & h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    case (mem_width_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr_i[0];
      2'b10:   misaligned = |mem_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign drain_now = drain | flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    dc_req_valid_o = 1'b0;
    stall_o        = 1'b0;
    done_o         = 1'b0;
    misalign_o     = 1'b0;
    bus_err_o      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid_req_i && !flush_i) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        dc_req_valid_o = 1'b1;
        stall_o        = 1'b1;
        if (dc_req_ready_i) state_nxt = WAIT;
        else if (flush_i)   state_nxt = IDLE;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dc_resp_valid_i || timeout) state_nxt = drain_now ? IDLE : DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        bus_err_o = err_armed;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flush seen at acceptance or during WAIT turns the rest of the access into a silent drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw        <= 1'b0;
      width     <= 2'b00;
      rdtype    <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      cnt       <= '0;
      err_armed <= 1'b0;
      drain     <= 1'b0;
      ld_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid_req_i && !flush_i && !misaligned) begin
            rw     <= mem_rw_i;
            width  <= mem_width_i;
            rdtype <= mem_rdtype_i;
            addr   <= mem_addr_i;
            wdata  <= mem_wr_data_i;
          end
        end
        REQ: begin
          if (dc_req_ready_i) begin
            cnt       <= '0;
            drain     <= flush_i;
            err_armed <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (flush_i) drain <= 1'b1;
          if (dc_resp_valid_i) begin
            if (!drain_now) ld_data <= load_format(dc_resp_rdata_i, width, rdtype, addr[1:0]);
          end else if (timeout && !drain_now) begin
            err_armed <= 1'b1;
            ld_data   <= '0;
          end
        end
        DONE: err_armed <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    dc_req_wstrb_o = 4'b0000;
    if (rw) begin
      case (width)
        2'b00:   dc_req_wstrb_o = 4'b0001 << addr[1:0];
        2'b01:   dc_req_wstrb_o = 4'b0011 << addr[1:0];
        default: dc_req_wstrb_o = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (width)
      2'b00:   dc_req_wdata_o = {4{wdata[7:0]}};
      2'b01:   dc_req_wdata_o = {2{wdata[15:0]}};
      default: dc_req_wdata_o = wdata;
    endcase
  end

  assign dc_req_rw_o   = rw;
  assign dc_req_addr_o = {addr[31:2], 2'b00};
  assign ld_data_o     = ld_data;

endmodule
